seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for N common-anode/cathode 7-segment digits; next generation of the
//  single-digit BCD decoder. Scans one digit per slot, decodes 0-9 (optionally A-F), supports
//  per-digit decimal point, global blank, leading-zero blanking and anti-ghost dead time.
//  Sits between the clock/counter datapath and the board display pins.
// PARAMETERS
//  N_DIGITS    4      digits scanned, 2..8
//  SCAN_DIV    50000  clk cycles per digit slot, >= 4
//  DEAD_CYC    2      cycles at start of each slot with all anodes inactive, 0..SCAN_DIV-2
//  HEX_EN      1      1: codes 10-15 show A,b,C,d,E,F; 0: codes 10-15 show blank
//  SEG_ACT_LOW 1      1: segment/dp active-low on pins; 0: active-high
//  AN_ACT_LOW  1      1: anode enables active-low on pins; 0: active-high
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  bcd_in      in   4*N_DIGITS  digit codes; digit k = bcd_in[4k+3:4k], digit 0 = rightmost
//  dp_in       in   N_DIGITS    decimal point request per digit
//  blank_in    in   1           1: all digits dark (scan continues)
//  lz_en       in   1           1: leading-zero blanking enabled
//  seg_out     out  7           {a,b,c,d,e,f,g}, pin polarity per SEG_ACT_LOW
//  dp_out      out  1           decimal point, pin polarity per SEG_ACT_LOW
//  an_out      out  N_DIGITS    one-hot digit enable, pin polarity per AN_ACT_LOW
//  frame_tick  out  1           1-cycle pulse in the cycle the shadow registers load
// BEHAVIOUR
//  Reset: cnt=0, idx=0, shadow bcd/dp/blank/lz=0; seg_out, dp_out, an_out all INACTIVE; frame_tick=0.
//  Prescaler cnt counts 0..SCAN_DIV-1, wraps to 0; at cnt==SCAN_DIV-1 idx advances, N_DIGITS-1 -> 0.
//  Shadow load: at cnt==SCAN_DIV-1 && idx==N_DIGITS-1 all four inputs captured; frame_tick=1 that cycle.
//    Display content changes only at frame boundaries (no tearing); inputs are otherwise ignored.
//  Outputs are registered: pin state in cycle t+1 reflects cnt/idx/shadow of cycle t.
//  Slot window: cnt < DEAD_CYC -> an_out, seg_out, dp_out all inactive; else an_out bit idx active,
//    seg/dp show shadow digit idx.
//  Decode (active-low raw, then inverted if SEG_ACT_LOW=0): 0=0000001 1=1001111 2=0010010
//    3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100
//    A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000 blank=1111111.
//  Leading-zero blank: lz_en=1 -> digit k (k>=1) blank when codes of digits N_DIGITS-1..k are all 0;
//    digit 0 never LZ-blanked; blanked digit keeps its dp (dp_in still honoured).
//  blank_in=1 (shadowed): seg and dp inactive for every digit; an_out still scans.
//  Priority: dead time > blank_in > LZ blank > decode.
//  rst mid-slot: all outputs inactive at once (async), scan restarts at idx 0, cnt 0.
// STRUCTURE
//  Package seg7_pkg: SEG_* 7-bit raw active-low constants (0-F, BLANK), function to log2 width.
//  Sub-module seg7_hex_decode (combinational, 4-bit code + hex_en -> 7-bit raw): used once.
//  Top holds prescaler, idx counter, shadow regs, LZ mask, output registers and polarity.
// TESTING (bench: N_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, HEX_EN=1, active-low)
//  Reset held 3 cycles -> seg_out=7'h7F, dp_out=1, an_out=4'hF, frame_tick=0 throughout.
//  bcd_in=16'h1234, dp_in=0 -> per slot 8 cycles: 2 cycles an=F, then digit0 an=1110 seg=1001100,
//    digit3 an=0111 seg=1001111; frame_tick every 32 cycles.
//  Change bcd_in mid-frame to 16'h5678 -> old digits until next frame_tick, then new ones; no mix.
//  bcd_in=16'h0070, lz_en=1 -> digits 3,2 seg=1111111, digit1 seg=0001111, digit0 seg=0000001;
//    lz_en=0 -> digits 3,2 show 0000001.
//  bcd_in=16'hABCD, HEX_EN=1 -> A,b,C,d patterns; rerun HEX_EN=0 -> all four digits 1111111.
//  dp_in=4'b0100, blank_in=1 then 0; assert rst mid-slot -> blank: seg/dp dark, an scans;
//    then dp_out=0 only in digit2 slot; rst: outputs inactive same cycle, restart at digit0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_* : raw segment patterns {a,b,c,d,e,f,g}, active-low (0 = segment lit)
//   width_of : counter width needed to hold values 0..n-1 (at least 1 bit)
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit decoder.
//   code    in  4  digit code 0-15
//   hex_en  in  1  1: codes 10-15 show A,b,C,d,E,F; 0: they show blank
//   seg_raw out 7  {a,b,c,d,e,f,g}, active-low
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_en,
   output logic [6:0] seg_raw
);

   logic [6:0] hex_pat;

   always_comb begin
      hex_pat = SEG_BLANK;
      seg_raw = SEG_BLANK;
      case (code)
         4'd10:   hex_pat = SEG_A;
         4'd11:   hex_pat = SEG_B;
         4'd12:   hex_pat = SEG_C;
         4'd13:   hex_pat = SEG_D;
         4'd14:   hex_pat = SEG_E;
         4'd15:   hex_pat = SEG_F;
         default: hex_pat = SEG_BLANK;
      endcase
      case (code)
         4'd0:    seg_raw = SEG_0;
         4'd1:    seg_raw = SEG_1;
         4'd2:    seg_raw = SEG_2;
         4'd3:    seg_raw = SEG_3;
         4'd4:    seg_raw = SEG_4;
         4'd5:    seg_raw = SEG_5;
         4'd6:    seg_raw = SEG_6;
         4'd7:    seg_raw = SEG_7;
         4'd8:    seg_raw = SEG_8;
         4'd9:    seg_raw = SEG_9;
         default: seg_raw = hex_en ? hex_pat : SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for N_DIGITS 7-segment digits.
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   bcd_in     in   4*N_DIGITS digit codes, digit 0 in bits [3:0] (rightmost)
//   dp_in      in   N_DIGITS decimal point requests
//   blank_in   in   1: all digits dark, scan continues
//   lz_en      in   1: leading-zero blanking
//   seg_out    out  {a,b,c,d,e,f,g}, polarity per SEG_ACT_LOW
//   dp_out     out  decimal point, polarity per SEG_ACT_LOW
//   an_out     out  one-hot digit enable, polarity per AN_ACT_LOW
//   frame_tick out  high in the cycle the shadow registers capture the inputs
// Inputs are sampled only at frame boundaries so a frame never mixes old and new content.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int SCAN_DIV    = 50000,
   parameter int DEAD_CYC    = 2,
   parameter int HEX_EN      = 1,
   parameter int SEG_ACT_LOW = 1,
   parameter int AN_ACT_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    blank_in,
   input  logic                    lz_en,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [N_DIGITS-1:0]     an_out,
   output logic                    frame_tick
);

   localparam int unsigned CNT_W = width_of(SCAN_DIV);
   localparam int unsigned IDX_W = width_of(N_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   localparam logic                SEG_LOW = (SEG_ACT_LOW != 0);
   localparam logic                AN_LOW  = (AN_ACT_LOW != 0);
   localparam logic                HEX_ON  = (HEX_EN != 0);
   localparam logic [6:0]          SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;
   localparam logic                DP_OFF  = SEG_LOW;
   localparam logic [N_DIGITS-1:0] AN_OFF  = AN_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [4*N_DIGITS-1:0] sh_bcd_q;
   logic [N_DIGITS-1:0]   sh_dp_q;
   logic                  sh_blank_q;
   logic                  sh_lz_q;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [N_DIGITS-1:0]   an_q, an_d;

   logic                  slot_end;
   logic                  frame_end;
   logic                  in_dead;
   logic [3:0]            cur_code;
   logic [6:0]            dec_raw;
   logic [6:0]            seg_raw;
   logic [N_DIGITS-1:0]   lz_mask;
   logic                  upper_zero;
   logic [N_DIGITS-1:0]   an_act;

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);
   assign in_dead   = (int'(cnt_q) < DEAD_CYC);

   // Prescaler and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (slot_end) begin
         cnt_q <= '0;
         idx_q <= frame_end ? '0 : idx_q + 1'b1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Shadow registers: the displayed content for the whole next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_bcd_q   <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= 1'b0;
         sh_lz_q    <= 1'b0;
      end else if (frame_end) begin
         sh_bcd_q   <= bcd_in;
         sh_dp_q    <= dp_in;
         sh_blank_q <= blank_in;
         sh_lz_q    <= lz_en;
      end
   end

   // Digit k is leading-zero blanked while every digit from the top down to k is zero.
   always_comb begin
      lz_mask    = '0;
      upper_zero = sh_lz_q;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (sh_bcd_q[4*k +: 4] == 4'h0);
         lz_mask[k] = upper_zero;
      end
   end

   assign cur_code = sh_bcd_q[{idx_q, 2'b00} +: 4];

   seg7_hex_decode u_decode (
      .code    (cur_code),
      .hex_en  (HEX_ON),
      .seg_raw (dec_raw)
   );

   always_comb begin
      seg_d   = SEG_OFF;
      dp_d    = DP_OFF;
      an_d    = AN_OFF;
      an_act  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
      seg_raw = lz_mask[idx_q] ? SEG_BLANK : dec_raw;
      if (!in_dead) begin
         an_d = AN_LOW ? ~an_act : an_act;
         if (!sh_blank_q) begin
            seg_d = SEG_LOW ? seg_raw : ~seg_raw;
            dp_d  = sh_dp_q[idx_q] ? ~DP_OFF : DP_OFF;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
         an_q  <= AN_OFF;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign an_out     = an_q;
   assign frame_tick = frame_end;

endmodule
